// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : Load/store unit between a CPU port and a word-wide data memory.
//            Sub-word stores use a read-modify-write cycle.
// Revision : 1.0
// ============================================================================
module dmem_lsu #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] c_depth = 32'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_adr;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_sext;
    logic [31:0] r_wd;
    logic [31:0] r_buf;
    logic [31:0] r_rd;
    logic        r_err;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Alignment and range check, evaluated on the live request at acceptance.
    always_comb begin
        w_req_err = 1'b0;
        case (size)
            2'b00:   w_req_err = 1'b0;
            2'b01:   w_req_err = adr[0];
            2'b10:   w_req_err = |adr[1:0];
            default: w_req_err = 1'b1;
        endcase
        if ({2'b00, adr[31:2]} >= c_depth) begin
            w_req_err = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_req_err) begin
                        w_next = DONE;
                    end else if (we && (size == 2'b10)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_we ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = mem_rd[7:0];
        case (r_adr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_adr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = mem_rd;
        endcase
    end

    // Lanes not selected by the store keep the word read during RD.
    always_comb begin
        w_merge = r_buf;
        case (r_size)
            2'b00: begin
                case (r_adr[1:0])
                    2'd0:    w_merge[7:0]   = r_wd[7:0];
                    2'd1:    w_merge[15:8]  = r_wd[7:0];
                    2'd2:    w_merge[23:16] = r_wd[7:0];
                    default: w_merge[31:24] = r_wd[7:0];
                endcase
            end
            2'b01: begin
                if (r_adr[1]) begin
                    w_merge[31:16] = r_wd[15:0];
                end else begin
                    w_merge[15:0] = r_wd[15:0];
                end
            end
            default: w_merge = r_wd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_adr   <= 32'h0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_wd    <= 32'h0;
            r_buf   <= 32'h0;
            r_rd    <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && req) begin
                r_adr  <= adr;
                r_size <= size;
                r_we   <= we;
                r_sext <= sext;
                r_wd   <= wd;
                r_err  <= w_req_err;
            end
            if (r_state == RD) begin
                r_buf <= mem_rd;
                if (!r_we) begin
                    r_rd <= w_load;
                end
            end
        end
    end

    assign rd      = r_rd;
    assign ack     = (r_state == DONE);
    assign err     = (r_state == DONE) && r_err;
    assign busy    = (r_state != IDLE);
    // Gated by reset so an access aborted in WR never reaches the memory.
    assign mem_we  = (r_state == WR) && !reset;
    assign mem_adr = (r_state == IDLE) ? 32'h0 : {r_adr[31:2], 2'b00};
    assign mem_wd  = w_merge;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Scoreboard bench for dmem_lsu with a behavioural data memory.
// Revision : 1.0
// ============================================================================
module tb_dmem_lsu;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, req, we, sext, load_mem;
    logic [1:0]  size;
    logic [31:0] adr, wd, rd, mem_adr, mem_wd, mem_rd;
    logic        ack, err, busy, mem_we;

    dmem_lsu #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
        .adr(adr), .wd(wd), .rd(rd), .ack(ack), .err(err), .busy(busy),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr   [0:DEPTH-1];
    logic [31:0] model_mem [0:DEPTH-1];

    assign mem_rd = mem_arr[mem_adr[7:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= model_mem[i];
        end else if (mem_we) begin
            mem_arr[mem_adr[7:2]] <= mem_wd;
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nwe;
        logic [31:0] wd;
        logic        is_load;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] adr;
        logic [31:0] wd;
    } stim_t;

    exp_t        sb[$];
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic push_expect(input logic pwe, input logic [1:0] psz, input logic psx,
                               input logic [31:0] padr, input logic [31:0] pwd);
        exp_t        e;
        logic [31:0] word, sh, mask;
        int          off;
        off       = int'(padr[1:0]);
        e.err     = (psz == 2'b11) || ((psz == 2'b01) && padr[0]) ||
                    ((psz == 2'b10) && (padr[1:0] != 2'b00)) || ((padr >> 2) >= 32'(DEPTH));
        e.is_load = !pwe;
        e.rd      = last_rd;
        e.nwe     = 0;
        e.wd      = 32'h0;
        if (e.err)                      e.lat = 1;
        else if (!pwe || psz == 2'b10)  e.lat = 2;
        else                            e.lat = 3;
        if (!e.err) begin
            word = model_mem[padr[7:2]];
            if (!pwe) begin
                sh = word >> (8 * off);
                if (psz == 2'b00)      e.rd = psx ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
                else if (psz == 2'b01) e.rd = psx ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
                else                   e.rd = word;
                last_rd = e.rd;
            end else begin
                mask = (psz == 2'b00) ? (32'hFF << (8 * off)) :
                       (psz == 2'b01) ? (32'hFFFF << (8 * off)) : 32'hFFFF_FFFF;
                e.wd  = (word & ~mask) | ((pwd << (8 * off)) & mask);
                e.nwe = 1;
                model_mem[padr[7:2]] = e.wd;
            end
        end
        sb.push_back(e);
    endtask

    // Drives one request from idle and observes it through to the return to IDLE.
    task automatic run_access(input logic pwe, input logic [1:0] psz, input logic psx,
                              input logic [31:0] padr, input logic [31:0] pwd,
                              output int olat, output logic [31:0] ord, output logic oerr,
                              output int onwe, output logic [31:0] owd);
        push_expect(pwe, psz, psx, padr, pwd);
        req = 1'b1; we = pwe; size = psz; sext = psx; adr = padr; wd = pwd;
        @(posedge clk); #1;
        olat = 1; onwe = 0; owd = 32'h0;
        while (!ack && olat < 8) begin
            if (mem_we) begin onwe++; owd = mem_wd; end
            adr = $urandom; wd = $urandom; size = 2'($urandom);
            we = 1'($urandom); sext = 1'($urandom);
            @(posedge clk); #1;
            olat++;
        end
        if (mem_we) onwe++;
        ord  = rd;
        oerr = err;
        if (!ack) olat = -1;
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        adr = 32'h0; wd = 32'h0; load_mem = 1'b1; last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        n_checks += 4;
        if ({ack, err, busy, mem_we} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags got %b want 0000", {ack, err, busy, mem_we});
        end
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_rd got %h want 0", rd); end
        if (mem_adr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_adr got %h want 0", mem_adr); end
        if (mem_wd !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wd got %h want 0", mem_wd); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        stim_t tbl [6];
        exp_t e; int lat, nwe; logic [31:0] ord, owd; logic oerr;
        tbl[0] = '{1'b0, 2'b00, 1'b1, 32'h15, 32'h0};
        tbl[1] = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0};
        tbl[2] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0};
        tbl[3] = '{1'b0, 2'b00, 1'b1, 32'h14, 32'h0};
        tbl[4] = '{1'b0, 2'b00, 1'b0, 32'h17, 32'h0};
        tbl[5] = '{1'b0, 2'b01, 1'b1, 32'h14, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run_access(tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].adr, tbl[i].wd, lat, ord, oerr, nwe, owd);
            e = sb.pop_front();
            n_checks += 4;
            if (lat !== e.lat) begin n_errors++; $display("FAIL load[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (oerr !== e.err) begin n_errors++; $display("FAIL load[%0d] err got %b want %b", i, oerr, e.err); end
            if (nwe !== e.nwe) begin n_errors++; $display("FAIL load[%0d] mem_we pulses got %0d want %0d", i, nwe, e.nwe); end
            if (ord !== e.rd) begin n_errors++; $display("FAIL load[%0d] rd got %h want %h", i, ord, e.rd); end
            if (i == 0) begin
                n_checks++;
                if (ord !== 32'hFFFF_FFAA) begin n_errors++; $display("FAIL load_sext_byte rd got %h want ffffffaa", ord); end
            end
        end
    endtask

    task automatic test_store();
        stim_t tbl [5];
        exp_t e; int lat, nwe; logic [31:0] ord, owd; logic oerr;
        tbl[0] = '{1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_00CC};
        tbl[1] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678};
        tbl[2] = '{1'b1, 2'b01, 1'b0, 32'h2A, 32'h5555_BEEF};
        tbl[3] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0};
        tbl[4] = '{1'b0, 2'b10, 1'b0, 32'h28, 32'h0};
        for (int i = 0; i < 5; i++) begin
            run_access(tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].adr, tbl[i].wd, lat, ord, oerr, nwe, owd);
            e = sb.pop_front();
            n_checks += 3;
            if (lat !== e.lat) begin n_errors++; $display("FAIL store[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (oerr !== e.err) begin n_errors++; $display("FAIL store[%0d] err got %b want %b", i, oerr, e.err); end
            if (nwe !== e.nwe) begin n_errors++; $display("FAIL store[%0d] mem_we pulses got %0d want %0d", i, nwe, e.nwe); end
            if (e.nwe == 1) begin
                n_checks++;
                if (owd !== e.wd) begin n_errors++; $display("FAIL store[%0d] mem_wd got %h want %h", i, owd, e.wd); end
            end
            if (e.is_load) begin
                n_checks++;
                if (ord !== e.rd) begin n_errors++; $display("FAIL store[%0d] readback got %h want %h", i, ord, e.rd); end
            end
        end
        n_checks++;
        if (mem_arr[5] !== 32'hCC99_AABB) begin n_errors++; $display("FAIL store_byte_mem got %h want cc99aabb", mem_arr[5]); end
    endtask

    task automatic test_errors();
        stim_t tbl [7];
        exp_t e; int lat, nwe; logic [31:0] ord, owd; logic oerr;
        tbl[0] = '{1'b0, 2'b01, 1'b0, 32'h13,  32'h0};
        tbl[1] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0};
        tbl[2] = '{1'b0, 2'b11, 1'b0, 32'h04,  32'h0};
        tbl[3] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0};
        tbl[4] = '{1'b0, 2'b10, 1'b0, 32'hFC,  32'h0};
        tbl[5] = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0};
        tbl[6] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF};
        for (int i = 0; i < 7; i++) begin
            run_access(tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].adr, tbl[i].wd, lat, ord, oerr, nwe, owd);
            e = sb.pop_front();
            n_checks += 4;
            if (lat !== e.lat) begin n_errors++; $display("FAIL err[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (oerr !== e.err) begin n_errors++; $display("FAIL err[%0d] err got %b want %b", i, oerr, e.err); end
            if (nwe !== e.nwe) begin n_errors++; $display("FAIL err[%0d] mem_we pulses got %0d want %0d", i, nwe, e.nwe); end
            if (ord !== e.rd) begin n_errors++; $display("FAIL err[%0d] rd got %h want %h", i, ord, e.rd); end
        end
        n_checks++;
        if (mem_adr !== 32'h0) begin n_errors++; $display("FAIL idle_mem_adr got %h want 0", mem_adr); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int n, n2; logic [31:0] rda, rdb; logic gap_busy;
        push_expect(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
        push_expect(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        req = 1'b1; we = 1'b0; size = 2'b00; sext = 1'b0; adr = 32'h15; wd = 32'h0;
        @(posedge clk); #1;
        n = 0;
        while (!ack && n < 8) begin @(posedge clk); #1; n++; end
        rda = rd;
        size = 2'b10; adr = 32'h20;
        @(posedge clk); #1;
        gap_busy = busy;
        @(posedge clk); #1;
        n2 = 1;
        while (!ack && n2 < 8) begin @(posedge clk); #1; n2++; end
        if (!ack) n2 = -1;
        rdb = rd;
        req = 1'b0;
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks += 4;
        if (rda !== e.rd) begin n_errors++; $display("FAIL b2b_first rd got %h want %h", rda, e.rd); end
        if (gap_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_gap busy got %b want 0", gap_busy); end
        e = sb.pop_front();
        if (n2 !== e.lat) begin n_errors++; $display("FAIL b2b_second latency got %0d want %0d", n2, e.lat); end
        if (rdb !== e.rd) begin n_errors++; $display("FAIL b2b_second rd got %h want %h", rdb, e.rd); end
    endtask

    task automatic test_reset_during_wr();
        int n;
        req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; adr = 32'h21; wd = 32'h0000_00EE;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!mem_we && n < 8) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!mem_we) begin n_errors++; $display("FAIL rst_wr reach_wr got mem_we=0 want 1"); end
        reset = 1'b1;
        @(posedge clk); #1;
        last_rd = 32'h0;
        n_checks += 4;
        if (mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_wr mem_we got %b want 0", mem_we); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_wr busy got %b want 0", busy); end
        if (mem_arr[8] !== model_mem[8]) begin n_errors++; $display("FAIL rst_wr target word got %h want %h", mem_arr[8], model_mem[8]); end
        if (rd !== 32'h0) begin n_errors++; $display("FAIL rst_wr rd got %h want 0", rd); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_held_req();
        exp_t e; int n;
        push_expect(1'b0, 2'b01, 1'b1, 32'h2A, 32'h0);
        reset = 1'b1; req = 1'b1; we = 1'b0; size = 2'b01; sext = 1'b1; adr = 32'h2A; wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL held_req busy_in_reset got %b want 0", busy); end
        @(posedge clk); #1;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL held_req accept busy got %b want 1", busy); end
        n = 1;
        while (!ack && n < 8) begin @(posedge clk); #1; n++; end
        if (!ack) n = -1;
        e = sb.pop_front();
        if (n !== e.lat) begin n_errors++; $display("FAIL held_req latency got %0d want %0d", n, e.lat); end
        if (rd !== e.rd) begin n_errors++; $display("FAIL held_req rd got %h want %h", rd, e.rd); end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
        model_mem[5] = 32'h8899_AABB;
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_back_to_back();
        test_reset_during_wr();
        test_reset_held_req();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DEPTH, default 64, word depth of the attached data memory, used for the range check.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port req  input  1  CPU access request, held high until ack is seen.
REQ-005 Port we  input  1  1 = store, 0 = load.
REQ-006 Port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Port sext  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-008 Port adr  input  32  byte address.
REQ-009 Port wd  input  32  store data, right-justified.
REQ-010 Port rd  output  32  load result, right-justified and extended.
REQ-011 Port ack  output  1  one-cycle completion pulse.
REQ-012 Port err  output  1  one-cycle error flag, coincident with ack.
REQ-013 Port busy  output  1  high in every state other than IDLE.
REQ-014 Port mem_we  output  1  word write strobe to data memory.
REQ-015 Port mem_adr  output  32  byte address to data memory, with bits [1:0] = 00.
REQ-016 Port mem_wd  output  32  merged write word.
REQ-017 Port mem_rd  input  32  combinational read word from data memory.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, WR, DONE.
REQ-019 Request fields adr, size, we, sext and wd SHALL be registered on the acceptance edge, defined as IDLE with req=1; inputs SHALL be ignored while busy=1.
REQ-020 IDLE transitions SHALL be:
- error → DONE (err set);
- load, or store with size ≠ 10 → RD;
- word store → WR.
REQ-021 RD SHALL capture mem_rd into a word buffer, then go to DONE for a load or WR for a store.
REQ-022 WR SHALL assert mem_we=1 for exactly one cycle with mem_wd = the merged word, then go to DONE.
REQ-023 In the merged word, the selected byte or halfword lanes SHALL come from wd and the other lanes from the RD buffer.
- Lane order is little-endian: byte offset 0 = bits [7:0], halfword offset 0 = bits [15:0].
REQ-024 DONE SHALL assert ack=1 for one cycle, then go to IDLE.
- rd SHALL be valid during DONE and held until the next acceptance.
REQ-025 Latency from the acceptance edge to ack high SHALL be:
- load: 2 cycles;
- word store: 2 cycles;
- byte or halfword store: 3 cycles;
- error: 1 cycle.
REQ-026 Load extraction SHALL select the byte at adr[1:0] or the halfword at adr[1], then sign- or zero-extend it to 32 bits per sext.
- Word loads SHALL pass through unchanged.
REQ-027 An error SHALL be flagged for any of:
- size=11;
- halfword with adr[0]=1;
- word with adr[1:0]≠00;
- adr[31:2] ≥ DEPTH.
REQ-028 On error: no mem_we pulse, err=1 and ack=1 in DONE, rd unchanged.
REQ-029 mem_adr SHALL equal {latched adr[31:2], 2'b00} in all states, and SHALL be 0 in IDLE.
REQ-030 If req is still high in IDLE after DONE, a new request SHALL be accepted.
- The CPU SHALL drop req in the cycle it sees ack.

Reset
REQ-031 While reset=1 at a clock edge, the following SHALL take effect at that edge:
- state → IDLE;
- ack, err, busy, mem_we → 0;
- rd, mem_adr, mem_wd, buffers → 0.
REQ-032 Reset asserted in any state, including WR, SHALL abort the access; no mem_we SHALL occur in the cycle after reset.
REQ-033 A request held high during reset SHALL be accepted at the first edge after reset deasserts.

Verification
REQ-034 Memory word 5 = 32'h8899AABB, load byte from adr=0x15 with sext=1 → ack 2 cycles after accept, rd=32'hFFFFFFAA, err=0.
REQ-035 Same word, load halfword from adr=0x16 with sext=0 → rd=32'h00008899.
REQ-036 Store byte wd=32'h000000CC to adr=0x17 → RD then WR, one mem_we pulse, mem_wd=32'hCC99AABB, ack 3 cycles after accept; a later word load from 0x14 returns 32'hCC99AABB.
REQ-037 Word store of 32'h12345678 to adr=0x20 → WR directly, mem_we for one cycle, ack 2 cycles after accept.
REQ-038 Halfword load from adr=0x13, and word load from adr=0x100 with DEPTH=64 → each gives err=1 and ack=1 one cycle after accept, no mem_we, rd unchanged.
REQ-039 Reset asserted during WR of a byte store → mem_we=0 and busy=0 in the next cycle, and the target word is unchanged.
